// File: rtl/l1i_refill_ctrl.sv
// L2-side refill controller for the L1 instruction cache: looks up a fetch,
// refills the missing (or straddled next) block from L2 and retries the lookup.
module l1i_refill_ctrl #(
    parameter int BLOCK_SIZE     = 128,
    parameter int TAG_SIZE       = 9,
    parameter int IDX_SIZE       = 6,
    parameter int WORD_SIZE      = 2,
    parameter int OFFSET_SIZE    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                                     clk_i,
    input  logic                                                     rst_i,
    input  logic                                                     cpu_req_i,
    input  logic [TAG_SIZE+IDX_SIZE+WORD_SIZE+OFFSET_SIZE-1:0]       cpu_addr_i,
    output logic                                                     cpu_done_o,
    output logic                                                     cpu_err_o,
    output logic                                                     busy_o,
    output logic                                                     l1_read_o,
    output logic                                                     l1_write_o,
    output logic                                                     l1_write_next_o,
    output logic [TAG_SIZE+IDX_SIZE+WORD_SIZE+OFFSET_SIZE-1:0]       l1_addr_o,
    output logic [BLOCK_SIZE-1:0]                                    l1_data_o,
    input  logic                                                     l1_hit_i,
    input  logic                                                     l1_miss_next_i,
    output logic                                                     l2_req_o,
    output logic [TAG_SIZE+IDX_SIZE-1:0]                             l2_addr_o,
    input  logic                                                     l2_ack_i,
    input  logic [BLOCK_SIZE-1:0]                                    l2_data_i
);

    localparam int ADDR_W = TAG_SIZE + IDX_SIZE + WORD_SIZE + OFFSET_SIZE;
    localparam int BLK_W  = TAG_SIZE + IDX_SIZE;
    localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX = 2'd2;
    localparam logic [BLK_W-1:0] BLK_ONE = {{(BLK_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CHECK = 3'd2,
        S_REQ   = 3'd3,
        S_FILL  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                  state_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [BLK_W-1:0]        l2_addr_q;
    logic [BLOCK_SIZE-1:0]   data_q;
    logic                    next_q;
    logic [1:0]              retry_q;
    logic [7:0]              tmo_q;
    logic                    read_q;
    logic                    write_q;
    logic                    write_next_q;
    logic                    l2_req_q;
    logic                    done_q;
    logic                    err_q;
    logic                    busy_q;
    logic [BLK_W-1:0]        blk_d;
    logic [BLK_W-1:0]        blk_next_d;

    // Block address of the latched request and its successor (wraps at the top).
    always_comb begin
        blk_d      = addr_q[ADDR_W-1 -: BLK_W];
        blk_next_d = blk_d + BLK_ONE;
    end

    // Control FSM; every output is a register updated on the state transition.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            l2_addr_q    <= '0;
            data_q       <= '0;
            next_q       <= 1'b0;
            retry_q      <= 2'd0;
            tmo_q        <= 8'd0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            write_next_q <= 1'b0;
            l2_req_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cpu_req_i) begin
                        addr_q  <= cpu_addr_i;
                        retry_q <= 2'd0;
                        read_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_READ;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_READ: begin
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    // A straddling fetch needs the next block even when this one hits.
                    if (l1_miss_next_i || !l1_hit_i) begin
                        read_q <= 1'b0;
                        if (retry_q == RETRY_MAX) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            next_q    <= l1_miss_next_i;
                            l2_addr_q <= l1_miss_next_i ? blk_next_d : blk_d;
                            l2_req_q  <= 1'b1;
                            tmo_q     <= 8'd0;
                            state_q   <= S_REQ;
                        end
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_REQ: begin
                    if (l2_ack_i) begin
                        data_q       <= l2_data_i;
                        l2_req_q     <= 1'b0;
                        write_q      <= 1'b1;
                        write_next_q <= next_q;
                        read_q       <= next_q;
                        state_q      <= S_FILL;
                    end else if (tmo_q == TMO_LAST) begin
                        tmo_q    <= tmo_q + 8'd1;
                        l2_req_q <= 1'b0;
                        err_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                S_FILL: begin
                    write_q      <= 1'b0;
                    write_next_q <= 1'b0;
                    read_q       <= 1'b1;
                    retry_q      <= retry_q + 2'd1;
                    state_q      <= S_READ;
                end
                S_DONE: begin
                    read_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    read_q       <= 1'b0;
                    write_q      <= 1'b0;
                    write_next_q <= 1'b0;
                    l2_req_q     <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_done_o      = done_q;
    assign cpu_err_o       = err_q;
    assign busy_o          = busy_q;
    assign l1_read_o       = read_q;
    assign l1_write_o      = write_q;
    assign l1_write_next_o = write_next_q;
    assign l1_addr_o       = addr_q;
    assign l1_data_o       = data_q;
    assign l2_req_o        = l2_req_q;
    assign l2_addr_o       = l2_addr_q;

endmodule

// File: tb/tb_l1i_refill_ctrl.sv
// Scoreboard bench for l1i_refill_ctrl with a small L1 model and an L2 responder.
module tb_l1i_refill_ctrl;

    localparam int K_REQ  = 1;
    localparam int K_FILL = 2;
    localparam int K_DONE = 3;
    localparam int K_ERR  = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          cpu_req_i;
    logic [18:0]   cpu_addr_i;
    logic          cpu_done_o, cpu_err_o, busy_o;
    logic          l1_read_o, l1_write_o, l1_write_next_o;
    logic [18:0]   l1_addr_o;
    logic [127:0]  l1_data_o;
    logic          l1_hit_i = 1'b0;
    logic          l1_miss_next_i = 1'b0;
    logic          l2_req_o;
    logic [14:0]   l2_addr_o;
    logic          l2_ack_i = 1'b0;
    logic [127:0]  l2_data_i = '0;

    always #5 clk = ~clk;

    l1i_refill_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i),
        .cpu_done_o(cpu_done_o), .cpu_err_o(cpu_err_o), .busy_o(busy_o),
        .l1_read_o(l1_read_o), .l1_write_o(l1_write_o), .l1_write_next_o(l1_write_next_o),
        .l1_addr_o(l1_addr_o), .l1_data_o(l1_data_o), .l1_hit_i(l1_hit_i),
        .l1_miss_next_i(l1_miss_next_i), .l2_req_o(l2_req_o), .l2_addr_o(l2_addr_o),
        .l2_ack_i(l2_ack_i), .l2_data_i(l2_data_i)
    );

    typedef struct {
        int           kind;
        logic         nxt;
        logic [127:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  n_req   = 0;
    int  n_wr    = 0;
    int  viol    = 0;
    logic req_prev = 1'b0;

    // L1 model state
    logic         vld [64];
    logic [8:0]   tg  [64];
    logic [127:0] dat [64];
    bit           l1_broken = 1'b0;

    // L2 responder controls
    int           l2_lat = 0;
    logic [127:0] l2_dv = '0;
    bit           force_ack = 1'b0;
    int           wcnt = 0;

    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] PAT  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] B0   = {32'h0017_0000, 32'h0, 32'h0000_0004, 32'h0};
    localparam logic [127:0] DRT  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic n, input logic [127:0] v);
        ev_t e;
        e.kind = k;
        e.nxt  = n;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int k, input logic n, input logic [127:0] v);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected: got event kind %0d value %0h, required none", k, v);
        end else begin
            e = exp_q.pop_front();
            chk("sb_kind", 128'(k), 128'(e.kind));
            chk("sb_value", v, e.val);
            if (k == K_FILL) chk("sb_write_next", {127'b0, n}, {127'b0, e.nxt});
        end
    endtask

    function automatic logic present(input logic [14:0] b);
        return vld[b[5:0]] && (tg[b[5:0]] == b[14:6]);
    endfunction

    function automatic logic [31:0] rd_word(input logic [18:0] a);
        logic [14:0]  b;
        logic [14:0]  nb;
        logic [127:0] cur;
        logic [127:0] nxt;
        b   = a[18:4];
        nb  = b + 15'd1;
        cur = dat[b[5:0]];
        nxt = dat[nb[5:0]];
        if (a[3:2] == 2'd3 && a[1:0] == 2'd2) return {nxt[15:0], cur[127:112]};
        return cur[32*a[3:2] +: 32];
    endfunction

    function automatic logic [18:0] mk(input logic [8:0] t, input logic [5:0] i,
                                       input logic [1:0] w, input logic [1:0] o);
        return {t, i, w, o};
    endfunction

    // L1 model: absorbs fills and presents hit/miss_next for the current address
    always @(negedge clk) begin
        logic [14:0] b;
        if (l1_write_o) begin
            n_wr++;
            if (!l1_broken) begin
                b = l1_addr_o[18:4] + (l1_write_next_o ? 15'd1 : 15'd0);
                vld[b[5:0]] = 1'b1;
                tg[b[5:0]]  = b[14:6];
                dat[b[5:0]] = l1_data_o;
            end
        end
        b = l1_addr_o[18:4];
        l1_hit_i       = present(b);
        l1_miss_next_i = (l1_addr_o[3:2] == 2'd3) && (l1_addr_o[1:0] == 2'd2) && !present(b + 15'd1);
    end

    // L2 responder: acks l2_lat cycles into a request; l2_lat of 0 never acks
    always @(negedge clk) begin
        l2_ack_i = 1'b0;
        if (force_ack) begin
            l2_ack_i  = 1'b1;
            l2_data_i = ONES;
        end else if (l2_req_o && l2_lat > 0) begin
            wcnt++;
            if (wcnt >= l2_lat) begin
                l2_ack_i  = 1'b1;
                l2_data_i = l2_dv;
                wcnt      = 0;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event
    always @(negedge clk) begin
        if (l2_req_o && !req_prev) begin
            n_req++;
            pop_cmp(K_REQ, 1'b0, {113'b0, l2_addr_o});
        end
        if (l1_write_o) pop_cmp(K_FILL, l1_write_next_o, l1_data_o);
        if (cpu_done_o) pop_cmp(K_DONE, 1'b0, {96'b0, rd_word(l1_addr_o)});
        if (cpu_err_o)  pop_cmp(K_ERR, 1'b0, 128'b0);
        if (l1_write_o && l2_req_o) viol++;
        req_prev = l2_req_o;
    end

    task automatic do_req(input logic [18:0] a);
        @(negedge clk);
        cpu_req_i  = 1'b1;
        cpu_addr_i = a;
        @(negedge clk);
        cpu_req_i  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while (busy_o && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk(name, {127'b0, busy_o}, 128'b0);
        @(negedge clk);
        @(negedge clk);
        chk({name, "_sb_empty"}, 128'(exp_q.size()), 128'd0);
    endtask

    task automatic wait_req(input string name);
        int c = 0;
        while (!l2_req_o && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk(name, {127'b0, l2_req_o}, 128'd1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_done"},  {127'b0, cpu_done_o}, 128'd0);
        chk({tag, "_err"},   {127'b0, cpu_err_o}, 128'd0);
        chk({tag, "_busy"},  {127'b0, busy_o}, 128'd0);
        chk({tag, "_read"},  {127'b0, l1_read_o}, 128'd0);
        chk({tag, "_write"}, {126'b0, l1_write_o, l1_write_next_o}, 128'd0);
        chk({tag, "_l1a"},   {109'b0, l1_addr_o}, 128'd0);
        chk({tag, "_l1d"},   l1_data_o, 128'd0);
        chk({tag, "_l2req"}, {127'b0, l2_req_o}, 128'd0);
        chk({tag, "_l2a"},   {113'b0, l2_addr_o}, 128'd0);
    endtask

    initial begin
        int lat;
        int n0;
        int cnt;
        rst_i      = 1'b1;
        cpu_req_i  = 1'b0;
        cpu_addr_i = '0;
        for (int i = 0; i < 64; i++) begin
            vld[i] = 1'b0;
            tg[i]  = '0;
            dat[i] = '0;
        end
        vld[0] = 1'b1;
        dat[0] = B0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_i = 1'b0;

        // 1: hit, done in the third cycle after acceptance, no L2 traffic
        n0 = n_req;
        push(K_DONE, 1'b0, 128'h0000_0004);
        do_req(mk(9'd0, 6'd0, 2'd1, 2'd0));
        lat = 1;
        while (!cpu_done_o && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("hit_latency", 128'(lat), 128'd3);
        wait_idle("hit_idle");
        chk("hit_no_l2", 128'(n_req - n0), 128'd0);

        // 2: cold miss, L2 acks after 4 cycles
        l2_lat = 4;
        l2_dv  = ONES;
        push(K_REQ, 1'b0, 128'h0041);
        push(K_FILL, 1'b0, ONES);
        push(K_DONE, 1'b0, 128'hFFFF_FFFF);
        do_req(mk(9'd1, 6'd1, 2'd0, 2'd0));
        wait_idle("cold_idle");

        // 3: next-block miss on a straddling fetch
        l2_lat = 2;
        l2_dv  = ONES;
        push(K_REQ, 1'b0, 128'h0001);
        push(K_FILL, 1'b1, ONES);
        push(K_DONE, 1'b0, 128'hFFFF_0017);
        do_req(mk(9'd0, 6'd0, 2'd3, 2'd2));
        wait_idle("next_idle");

        // 4: next-block address wraps from 0x7FFF to 0x0000
        vld[0]  = 1'b0;
        vld[63] = 1'b1;
        tg[63]  = 9'h1FF;
        dat[63] = {32'hABCD_0000, 96'b0};
        l2_lat  = 3;
        l2_dv   = PAT;
        push(K_REQ, 1'b0, 128'h0000);
        push(K_FILL, 1'b1, PAT);
        push(K_DONE, 1'b0, 128'h3210_ABCD);
        do_req(mk(9'h1FF, 6'h3F, 2'd3, 2'd2));
        wait_idle("wrap_idle");

        // 5: L2 timeout, then a late ack that must be ignored
        l2_lat = 0;
        push(K_REQ, 1'b0, 128'h0085);
        push(K_ERR, 1'b0, 128'b0);
        do_req(mk(9'd2, 6'd5, 2'd0, 2'd0));
        wait_req("tmo_req_seen");
        cnt = 0;
        while (l2_req_o && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        chk("tmo_req_cycles", 128'(cnt), 128'd255);
        chk("tmo_err", {127'b0, cpu_err_o}, 128'd1);
        chk("tmo_busy", {127'b0, busy_o}, 128'd0);
        n0 = n_wr;
        force_ack = 1'b1;
        repeat (2) @(negedge clk);
        force_ack = 1'b0;
        repeat (4) @(negedge clk);
        chk("late_ack_no_write", 128'(n_wr - n0), 128'd0);
        chk("late_ack_data", l1_data_o, PAT);
        wait_idle("tmo_idle");

        // Retry limit: fills never land, third lookup reports an error
        l1_broken = 1'b1;
        l2_lat    = 1;
        l2_dv     = DRT;
        push(K_REQ, 1'b0, 128'h0109);
        push(K_FILL, 1'b0, DRT);
        push(K_REQ, 1'b0, 128'h0109);
        push(K_FILL, 1'b0, DRT);
        push(K_ERR, 1'b0, 128'b0);
        do_req(mk(9'd4, 6'd9, 2'd0, 2'd0));
        wait_idle("retry_idle");
        l1_broken = 1'b0;

        // 6: reset while a request is pending, then a normal hit
        l2_lat = 0;
        push(K_REQ, 1'b0, 128'h00C7);
        do_req(mk(9'd3, 6'd7, 2'd0, 2'd0));
        wait_req("rst_req_seen");
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk_outputs_zero("midreset");
        vld[0] = 1'b1;
        tg[0]  = 9'd0;
        dat[0] = B0;
        push(K_DONE, 1'b0, 128'h0000_0004);
        do_req(mk(9'd0, 6'd0, 2'd1, 2'd0));
        wait_idle("post_rst_idle");

        chk("write_req_exclusive", 128'(viol), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
